// File: rtl/npu_conv_engine.sv
// 8-channel 3x3 convolution engine: nine byte-wide feature banks, per-channel weights and
// biases, multi-pass 24-bit accumulation, shift/saturate, optional ReLU and 2x2 max-pool.
module npu_conv_engine #(
  parameter int WIDTH    = 80,
  parameter int HEIGHT   = 8,
  parameter int WIDTH_B  = 7,
  parameter int HEIGHT_B = 3,
  parameter int MAX_PASS = 2,
  parameter int ACC_W    = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH_B-1:0]    write_w,
  input  logic [HEIGHT_B-1:0]   write_h,
  input  logic [71:0]           data_in,
  input  logic [8:0]            en_in,
  input  logic [9*WIDTH_B-1:0]  readi_w,
  input  logic [9*HEIGHT_B-1:0] readi_h,
  input  logic [8:0]            en_read,
  input  logic                  en_bias,
  input  logic [2:0]            step,
  input  logic                  en_pe,
  input  logic [2:0]            bound_level,
  input  logic [2:0]            step_p,
  input  logic                  en_relu,
  input  logic                  en_mp,
  output logic [63:0]           out,
  output logic [7:0]            out_en
);
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int NCH    = 8;
  localparam int NTAP   = 9;
  localparam int PASS_B = (MAX_PASS > 1) ? $clog2(MAX_PASS) : 1;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam logic signed [ACC_W-1:0] U_MAX = 255;
  localparam logic signed [ACC_W-1:0] S_MAX = 127;
  localparam logic signed [ACC_W-1:0] S_MIN = -128;

  function automatic logic [DATA_W-1:0] sat8(input logic signed [ACC_W-1:0] v, input logic relu);
    if (relu) begin
      if (v < 0)          sat8 = 8'h00;
      else if (v > U_MAX) sat8 = 8'hFF;
      else                sat8 = v[DATA_W-1:0];
    end else begin
      if (v < S_MIN)      sat8 = 8'h80;
      else if (v > S_MAX) sat8 = 8'h7F;
      else                sat8 = v[DATA_W-1:0];
    end
  endfunction

  function automatic logic gt8(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic uns);
    gt8 = uns ? (a > b) : ($signed(a) > $signed(b));
  endfunction

  logic        [DATA_W-1:0] bank   [NTAP][HEIGHT][WIDTH];
  logic signed [COEF_W-1:0] weight [NCH][MAX_PASS][NTAP];
  logic signed [15:0]       bias   [NCH];

  logic [DATA_W-1:0] byte_in [NTAP];
  logic [DATA_W-1:0] tap_rd  [NTAP];
  logic              wr_param;
  logic [WIDTH_B-1:0]  rw;
  logic [HEIGHT_B-1:0] rh;

  // Parameter writes take priority over bank writes; en_pe with a nonzero mask never lands in a bank.
  assign wr_param = en_bias || (en_pe && (en_in != '0));

  always_comb begin
    rw = '0;
    rh = '0;
    for (int k = 0; k < NTAP; k++) begin
      byte_in[k] = data_in[71-8*k -: 8];
      tap_rd[k]  = '0;
      rw = readi_w[9*WIDTH_B-1-WIDTH_B*k -: WIDTH_B];
      rh = readi_h[9*HEIGHT_B-1-HEIGHT_B*k -: HEIGHT_B];
      if (en_read[k] && (32'(rw) < WIDTH) && (32'(rh) < HEIGHT))
        tap_rd[k] = bank[k][rh][rw];
    end
  end

  always_ff @(posedge clk) begin
    if (!wr_param && (32'(write_w) < WIDTH) && (32'(write_h) < HEIGHT))
      for (int k = 0; k < NTAP; k++)
        if (en_in[k]) bank[k][write_h][write_w] <= byte_in[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        bias[c] <= '0;
        for (int p = 0; p < MAX_PASS; p++)
          for (int k = 0; k < NTAP; k++) weight[c][p][k] <= '0;
      end
    end else if (en_bias) begin
      bias[write_h] <= $signed(data_in[15:0]);
    end else if (en_pe && (en_in != '0) && (32'(step) < MAX_PASS)) begin
      for (int k = 0; k < NTAP; k++)
        if (en_in[k]) weight[write_h][step[PASS_B-1:0]][k] <= $signed(byte_in[k]);
    end
  end

  // Stage p0: registered taps and the beat's control snapshot
  logic              vld_p0;
  logic [DATA_W-1:0] tap_p0 [NTAP];
  logic [2:0]        step_p0;
  logic [PASS_B-1:0] pidx_p0;
  logic              last_p0, relu_p0, mp_p0;
  logic [2:0]        bound_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= (en_read != '0) && (32'(step) < MAX_PASS);
  end

  always_ff @(posedge clk) begin
    tap_p0   <= tap_rd;
    step_p0  <= step;
    pidx_p0  <= step[PASS_B-1:0];
    last_p0  <= (step == step_p);
    bound_p0 <= bound_level;
    relu_p0  <= en_relu;
    mp_p0    <= en_mp;
  end

  // Stage p1: 9-tap MAC per channel, accumulate, then shift and saturate
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  acc     [NCH];
  logic signed [ACC_W-1:0]  acc_nxt [NCH];
  logic        [DATA_W-1:0] res_nxt [NCH];
  logic                     vld_p1, relu_p1, mp_p1;
  logic        [DATA_W-1:0] res_p1  [NCH];

  always_comb begin
    prod = '0;
    sum  = '0;
    for (int c = 0; c < NCH; c++) begin
      sum = '0;
      for (int k = 0; k < NTAP; k++) begin
        prod = PROD_W'($signed({1'b0, tap_p0[k]})) * PROD_W'(weight[c][pidx_p0][k]);
        sum  = sum + ACC_W'(prod);
      end
      acc_nxt[c] = ((step_p0 == 3'd0) ? ACC_W'(bias[c]) : acc[c]) + sum;
      res_nxt[c] = sat8(acc_nxt[c] >>> bound_p0, relu_p0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
    end else begin
      vld_p1 <= vld_p0 && last_p0;
      if (vld_p0) acc <= acc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    res_p1  <= res_nxt;
    relu_p1 <= relu_p0;
    mp_p1   <= mp_p0;
  end

  // Stage p2: direct output or 2x2 pool reduction over four finalized results
  logic [1:0]        pcnt;
  logic [DATA_W-1:0] pmax     [NCH];
  logic [DATA_W-1:0] pool_nxt [NCH];

  always_comb begin
    for (int c = 0; c < NCH; c++)
      pool_nxt[c] = ((pcnt == 2'd0) || gt8(res_p1[c], pmax[c], relu_p1)) ? res_p1[c] : pmax[c];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out    <= '0;
      out_en <= '0;
      pcnt   <= '0;
      for (int c = 0; c < NCH; c++) pmax[c] <= '0;
    end else begin
      out_en <= '0;
      if (vld_p1) begin
        if (!mp_p1) begin
          for (int c = 0; c < NCH; c++) out[63-8*c -: 8] <= res_p1[c];
          out_en <= 8'hFF;
        end else if (pcnt == 2'd3) begin
          for (int c = 0; c < NCH; c++) begin
            out[63-8*c -: 8] <= pool_nxt[c];
            pmax[c] <= '0;
          end
          out_en <= 8'hFF;
          pcnt   <= '0;
        end else begin
          pmax <= pool_nxt;
          pcnt <= pcnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_npu_conv_engine.sv
// Bench for npu_conv_engine: directed tables and sequences, then random beats
// checked against an arithmetic reference model.
module tb_npu_conv_engine;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  write_w;
  logic [2:0]  write_h;
  logic [71:0] data_in;
  logic [8:0]  en_in;
  logic [62:0] readi_w;
  logic [26:0] readi_h;
  logic [8:0]  en_read;
  logic        en_bias;
  logic [2:0]  step;
  logic        en_pe;
  logic [2:0]  bound_level;
  logic [2:0]  step_p;
  logic        en_relu;
  logic        en_mp;
  logic [63:0] out;
  logic [7:0]  out_en;

  always #5 clk = ~clk;

  npu_conv_engine dut (
    .clk(clk), .reset(reset), .write_w(write_w), .write_h(write_h), .data_in(data_in),
    .en_in(en_in), .readi_w(readi_w), .readi_h(readi_h), .en_read(en_read),
    .en_bias(en_bias), .step(step), .en_pe(en_pe), .bound_level(bound_level),
    .step_p(step_p), .en_relu(en_relu), .en_mp(en_mp), .out(out), .out_en(out_en)
  );

  typedef struct { int bias; int bound; bit relu; logic [7:0] exp; } vec_t;
  typedef struct { logic [7:0] en; logic [63:0] out; } exp_t;

  int         bank_m   [9][8][80];
  int         weight_m [8][2][9];
  int         bias_m   [8];
  int         acc_m    [8];
  logic [7:0] pool_v   [4][8];
  bit         pool_r   [4];
  int         pool_n;
  exp_t       exp_q[$];
  vec_t       tbl [15];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_in = '0; en_read = '0; en_bias = 1'b0; en_pe = 1'b0;
  endtask

  task automatic wr_bank(input int h, input int w, input logic [71:0] d);
    idle(); write_h = 3'(h); write_w = 7'(w); data_in = d; en_in = 9'h1FF;
    if (w < 80) for (int k = 0; k < 9; k++) bank_m[k][h][w] = int'(d[71-8*k -: 8]);
    tick(); idle();
  endtask

  task automatic wr_w(input int ch, input int st, input logic [71:0] d);
    idle(); write_h = 3'(ch); step = 3'(st); data_in = d; en_in = 9'h1FF; en_pe = 1'b1;
    for (int k = 0; k < 9; k++) weight_m[ch][st][k] = int'($signed(d[71-8*k -: 8]));
    tick(); idle();
  endtask

  task automatic wr_bias(input int ch, input int val);
    logic [15:0] v16;
    v16 = 16'(val);
    idle(); write_h = 3'(ch); data_in = {56'h0, v16}; en_bias = 1'b1;
    bias_m[ch] = int'($signed(v16));
    tick(); idle();
  endtask

  task automatic do_beat(input logic [8:0] enr, input logic [2:0] st, input logic [6:0] rw);
    en_read = enr; step = st; readi_w = {9{rw}}; readi_h = '0;
    tick();
    en_read = '0;
  endtask

  function automatic logic [7:0] clampv(input int v, input bit relu);
    if (relu) return (v < 0) ? 8'h00 : (v > 255) ? 8'hFF : 8'(v);
    return (v < -128) ? 8'h80 : (v > 127) ? 8'h7F : 8'(v);
  endfunction

  // Reference: one beat as seen at the inputs this cycle, yielding the output three cycles later.
  task automatic model_beat(output exp_t e);
    int tap [9];
    int w, h, sum, m_idx;
    logic [7:0] res [8];
    logic [7:0] m, v;
    e.en = '0; e.out = '0;
    if (en_read == '0 || step >= 3'd2) return;
    for (int k = 0; k < 9; k++) begin
      w = int'(readi_w[62-7*k -: 7]);
      h = int'(readi_h[26-3*k -: 3]);
      tap[k] = (en_read[k] && w < 80) ? bank_m[k][h][w] : 0;
    end
    for (int c = 0; c < 8; c++) begin
      sum = 0;
      for (int k = 0; k < 9; k++) sum += tap[k] * weight_m[c][step][k];
      acc_m[c] = ((step == 3'd0) ? bias_m[c] : acc_m[c]) + sum;
    end
    if (step != step_p) return;
    for (int c = 0; c < 8; c++) res[c] = clampv(acc_m[c] >>> bound_level, en_relu);
    if (!en_mp) begin
      e.en = 8'hFF;
      for (int c = 0; c < 8; c++) e.out[63-8*c -: 8] = res[c];
      return;
    end
    m_idx = pool_n;
    pool_r[m_idx] = en_relu;
    for (int c = 0; c < 8; c++) pool_v[m_idx][c] = res[c];
    pool_n++;
    if (pool_n == 4) begin
      for (int c = 0; c < 8; c++) begin
        m = pool_v[0][c];
        for (int j = 1; j < 4; j++) begin
          v = pool_v[j][c];
          if (pool_r[j] ? (v > m) : ($signed(v) > $signed(m))) m = v;
        end
        e.out[63-8*c -: 8] = m;
      end
      e.en = 8'hFF;
      pool_n = 0;
    end
  endtask

  initial begin
    exp_t e;
    int vals [8];
    int r;
    logic [71:0] d;

    tbl[0]  = '{1000, 2, 1'b1, 8'd250};
    tbl[1]  = '{2000, 2, 1'b1, 8'd255};
    tbl[2]  = '{-100, 0, 1'b1, 8'h00};
    tbl[3]  = '{-100, 0, 1'b0, 8'h9C};
    tbl[4]  = '{-1000, 0, 1'b0, 8'h80};
    tbl[5]  = '{127, 0, 1'b0, 8'h7F};
    tbl[6]  = '{128, 0, 1'b0, 8'h7F};
    tbl[7]  = '{-128, 0, 1'b0, 8'h80};
    tbl[8]  = '{-129, 0, 1'b0, 8'h80};
    tbl[9]  = '{255, 0, 1'b1, 8'hFF};
    tbl[10] = '{256, 0, 1'b1, 8'hFF};
    tbl[11] = '{-3, 1, 1'b0, 8'hFE};
    tbl[12] = '{-1, 7, 1'b0, 8'hFF};
    tbl[13] = '{511, 1, 1'b1, 8'hFF};
    tbl[14] = '{-32768, 7, 1'b0, 8'h80};

    reset = 1'b1; write_w = '0; write_h = '0; data_in = '0; readi_w = '0; readi_h = '0;
    step = '0; bound_level = '0; step_p = '0; en_relu = 1'b1; en_mp = 1'b0; idle();
    for (int c = 0; c < 8; c++) begin
      bias_m[c] = 0; acc_m[c] = 0;
      for (int p = 0; p < 2; p++) for (int k = 0; k < 9; k++) weight_m[c][p][k] = 0;
    end
    pool_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", out, 64'h0);
    chk("reset_out_en", {56'h0, out_en}, 64'h0);
    reset = 1'b0;
    tick();

    // Single full-tap beat
    wr_bank(0, 0, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
    wr_w(0, 0, {9{8'd1}});
    do_beat(9'h1FF, 3'd0, 7'd0);
    tick();
    chk("beat_early_en", {56'h0, out_en}, 64'h0);
    tick();
    chk("beat_en", {56'h0, out_en}, 64'hFF);
    chk("beat_out", out, {8'd45, 56'h0});
    tick();
    chk("beat_en_drop", {56'h0, out_en}, 64'h0);
    chk("beat_out_hold", out, {8'd45, 56'h0});

    // Bias / shift / saturation table; taps are zero via an out-of-range column
    foreach (tbl[i]) begin
      wr_bias(0, tbl[i].bias);
      bound_level = 3'(tbl[i].bound);
      en_relu = tbl[i].relu;
      do_beat(9'h001, 3'd0, 7'd100);
      tick(); tick();
      chk($sformatf("tbl%0d_en", i), {56'h0, out_en}, 64'hFF);
      chk($sformatf("tbl%0d_out", i), out, {tbl[i].exp, 56'h0});
    end
    wr_bias(0, 0);
    bound_level = 3'd0; en_relu = 1'b1;

    // Two-pass accumulation, back-to-back beats
    wr_w(0, 0, {8'd1, 56'h0, 8'd1});
    wr_w(0, 1, {8'd0, 8'd1, 48'h0, 8'd2});
    step_p = 3'd1;
    en_read = 9'h1FF; readi_w = '0; readi_h = '0; step = 3'd0;
    tick();
    step = 3'd1;
    tick();
    en_read = '0;
    tick();
    chk("pass0_no_en", {56'h0, out_en}, 64'h0);
    tick();
    chk("pass1_en", {56'h0, out_en}, 64'hFF);
    chk("pass1_out", out, {8'd30, 56'h0});
    step_p = 3'd0;

    // Max-pool: two groups of four
    vals = '{3, 7, 5, 1, 2, 2, 9, 4};
    en_mp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_bias(0, vals[i]);
      do_beat(9'h001, 3'd0, 7'd100);
      tick(); tick();
      chk($sformatf("pool%0d_en", i), {56'h0, out_en}, (i % 4 == 3) ? 64'hFF : 64'h0);
      if (i == 3) chk("pool_grp0_out", out, {8'd7, 56'h0});
      if (i == 7) chk("pool_grp1_out", out, {8'd9, 56'h0});
    end

    // Asynchronous reset while a result is on the output and the pool holds two entries
    wr_bias(0, 50);
    do_beat(9'h001, 3'd0, 7'd100);
    do_beat(9'h001, 3'd0, 7'd100);
    en_mp = 1'b0;
    do_beat(9'h001, 3'd0, 7'd100);
    tick(); tick();
    chk("prerst_en", {56'h0, out_en}, 64'hFF);
    chk("prerst_out", out, {8'd50, 56'h0});
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out", out, 64'h0);
    chk("async_rst_en", {56'h0, out_en}, 64'h0);
    #2 reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bias_m[c] = 0;
      for (int p = 0; p < 2; p++) for (int k = 0; k < 9; k++) weight_m[c][p][k] = 0;
    end
    tick();
    do_beat(9'h1FF, 3'd0, 7'd0);
    tick(); tick();
    chk("postrst_en", {56'h0, out_en}, 64'hFF);
    chk("postrst_out", out, 64'h0);
    en_mp = 1'b1;
    for (int j = 0; j < 4; j++) begin
      do_beat(9'h1FF, 3'd0, 7'd0);
      tick(); tick();
      chk($sformatf("postrst_pool%0d_en", j), {56'h0, out_en}, (j == 3) ? 64'hFF : 64'h0);
    end
    chk("postrst_pool_out", out, 64'h0);
    pool_n = 0;

    // Random beats against the reference model
    for (int h = 0; h < 8; h++)
      for (int j = 0; j < 8; j++) begin
        d = {8'($urandom), 32'($urandom), 32'($urandom)};
        wr_bank(h, (j < 4) ? j : 72 + j, d);
      end
    for (int c = 0; c < 8; c++) begin
      for (int p = 0; p < 2; p++) begin
        d = {8'($urandom), 32'($urandom), 32'($urandom)};
        wr_w(c, p, d);
      end
      wr_bias(c, int'($urandom % 65536) - 32768);
    end
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front();
        chk("rand_en", {56'h0, out_en}, {56'h0, e.en});
        if (e.en != '0) chk("rand_out", out, e.out);
      end
      if (i < 397 && (i == 0 || $urandom % 4 != 0)) begin
        en_read = 9'($urandom);
        if (en_read == '0) en_read = 9'h001;
        for (int k = 0; k < 9; k++) begin
          r = int'($urandom % 12);
          readi_w[62-7*k -: 7] = 7'((r < 4) ? r : r + 72);
          readi_h[26-3*k -: 3] = 3'($urandom % 8);
        end
        step        = (i == 0) ? 3'd0 : 3'($urandom % 3);
        step_p      = 3'($urandom % 2);
        bound_level = 3'($urandom % 8);
        en_relu     = 1'($urandom % 2);
        en_mp       = 1'($urandom % 2);
      end else begin
        en_read = '0;
      end
      model_beat(e);
      exp_q.push_back(e);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
